// File: rtl/vga_mon_defs.sv
// Shared definitions for the VGA frame monitor: default 640x480 timing,
// CRC constants, error flag indices and FSM state encodings.
package vga_mon_defs;

    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_H_TOTAL   = 800;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;
    localparam int DEF_V_TOTAL   = 525;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    localparam int ERR_HWIDTH  = 0;
    localparam int ERR_HPERIOD = 1;
    localparam int ERR_VWIDTH  = 2;
    localparam int ERR_VPERIOD = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } mon_state_e;

endpackage

// File: rtl/crc16_pix.sv
// Combinational CRC-16-CCITT step over one pixel word, MSB first.
module crc16_pix
    import vga_mon_defs::*;
#(
    parameter int RGB_W = 12
) (
    input  logic [15:0]      i_crc,
    input  logic [RGB_W-1:0] i_pix,
    output logic [15:0]      o_crc
);

    always_comb begin
        logic [15:0] w_c;
        w_c = i_crc;
        for (int i = RGB_W - 1; i >= 0; i--) begin
            if (w_c[15] ^ i_pix[i]) w_c = {w_c[14:0], 1'b0} ^ CRC_POLY;
            else                    w_c = {w_c[14:0], 1'b0};
        end
        o_crc = w_c;
    end

endmodule

// File: rtl/vga_frame_monitor.sv
// Pixel-stream monitor: locks onto VGA sync timing, flags sync width/period
// errors and publishes a CRC-16 signature and pixel count per clean frame.
module vga_frame_monitor
    import vga_mon_defs::*;
#(
    parameter int RGB_W     = 12,
    parameter int H_DISPLAY = DEF_H_DISPLAY,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int H_TOTAL   = DEF_H_TOTAL,
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter int V_TOTAL   = DEF_V_TOTAL,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             p_tick,
    input  logic             hsync,
    input  logic             vsync,
    input  logic [RGB_W-1:0] rgb,
    input  logic             err_clr,
    output logic             locked,
    output logic             frame_valid,
    output logic [15:0]      frame_crc,
    output logic [19:0]      frame_pix,
    output logic [3:0]       err
);

    localparam int HW = $clog2(H_TOTAL) + 1;
    localparam int VW = $clog2(V_TOTAL) + 1;

    localparam logic [HW-1:0] H_MAX    = '1;
    localparam logic [HW-1:0] H_SYNC_C = HW'(H_SYNC);
    localparam logic [HW-1:0] H_LAST_C = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_LO = HW'(H_SYNC + H_BACK);
    localparam logic [HW-1:0] H_ACT_HI = HW'(H_SYNC + H_BACK + H_DISPLAY);
    localparam logic [VW-1:0] V_MAX    = '1;
    localparam logic [VW-1:0] V_SYNC_C = VW'(V_SYNC);
    localparam logic [VW-1:0] V_TOT_C  = VW'(V_TOTAL);
    localparam logic [VW-1:0] V_ACT_LO = VW'(V_SYNC + V_BACK);
    localparam logic [VW-1:0] V_ACT_HI = VW'(V_SYNC + V_BACK + V_DISPLAY);

    mon_state_e      r_state, w_next;
    logic            r_hs_prev, r_vs_prev, r_frame_err;
    logic [HW-1:0]   r_hpos;
    logic [VW-1:0]   r_vline;
    logic [15:0]     r_crc;
    logic [19:0]     r_pix;

    logic            w_hs_act, w_vs_act, w_hs_rise, w_hs_fall, w_vs_rise, w_vs_fall;
    logic [HW-1:0]   w_hpos_cur;
    logic [VW-1:0]   w_vline_inc, w_vline_cur;
    logic            w_active, w_chk_en, w_any_fail, w_frame_clean, w_pulse;
    logic [3:0]      w_fail;
    logic [15:0]     w_crc_next;

    // Syncs are normalised to "active = 1" so the rest of the logic ignores polarity.
    assign w_hs_act  = (hsync == SYNC_POL);
    assign w_vs_act  = (vsync == SYNC_POL);
    assign w_hs_rise = p_tick &  w_hs_act & ~r_hs_prev;
    assign w_hs_fall = p_tick & ~w_hs_act &  r_hs_prev;
    assign w_vs_rise = p_tick &  w_vs_act & ~r_vs_prev;
    assign w_vs_fall = p_tick & ~w_vs_act &  r_vs_prev;

    // Positions of the pixel carried by the current tick.
    assign w_hpos_cur  = w_hs_rise ? '0 : ((r_hpos == H_MAX) ? r_hpos : r_hpos + 1'b1);
    assign w_vline_inc = (w_hs_rise && (r_vline != V_MAX)) ? r_vline + 1'b1 : r_vline;
    assign w_vline_cur = w_vs_rise ? '0 : w_vline_inc;

    assign w_active = p_tick
                    && (w_hpos_cur  >= H_ACT_LO) && (w_hpos_cur  < H_ACT_HI)
                    && (w_vline_cur >= V_ACT_LO) && (w_vline_cur < V_ACT_HI);

    assign w_chk_en = (r_state != IDLE);
    assign w_fail[ERR_HWIDTH]  = w_chk_en & w_hs_fall & (w_hpos_cur  != H_SYNC_C);
    assign w_fail[ERR_HPERIOD] = w_chk_en & w_hs_rise & (r_hpos      != H_LAST_C);
    assign w_fail[ERR_VWIDTH]  = w_chk_en & w_vs_fall & (w_vline_cur != V_SYNC_C);
    assign w_fail[ERR_VPERIOD] = w_chk_en & w_vs_rise & (w_vline_inc != V_TOT_C);
    assign w_any_fail    = |w_fail;
    assign w_frame_clean = ~r_frame_err & ~w_any_fail;

    crc16_pix #(.RGB_W(RGB_W)) u_crc (
        .i_crc (r_crc),
        .i_pix (rgb),
        .o_crc (w_crc_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_vs_rise)                  w_next = ACQ;
            ACQ:     if (w_vs_rise && w_frame_clean) w_next = LOCK;
            LOCK:    if (w_any_fail)                 w_next = ACQ;
            default:                                 w_next = IDLE;
        endcase
    end

    always_comb begin
        w_pulse = w_vs_rise && w_frame_clean && ((r_state == ACQ) || (r_state == LOCK));
        locked  = (r_state == LOCK);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hs_prev   <= 1'b0;
            r_vs_prev   <= 1'b0;
            r_hpos      <= '0;
            r_vline     <= '0;
            r_frame_err <= 1'b0;
            r_crc       <= CRC_INIT;
            r_pix       <= '0;
        end else if (p_tick) begin
            r_hs_prev <= w_hs_act;
            r_vs_prev <= w_vs_act;
            r_hpos    <= w_hpos_cur;
            r_vline   <= w_vline_cur;
            if (w_vs_rise) begin
                r_frame_err <= 1'b0;
                r_crc       <= CRC_INIT;
                r_pix       <= '0;
            end else begin
                if (w_any_fail) r_frame_err <= 1'b1;
                if (w_active) begin
                    r_crc <= w_crc_next;
                    r_pix <= r_pix + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_valid <= 1'b0;
            frame_crc   <= '0;
            frame_pix   <= '0;
            err         <= '0;
        end else begin
            frame_valid <= w_pulse;
            if (w_pulse) begin
                frame_crc <= r_crc;
                frame_pix <= r_pix;
            end
            // A new error wins over a simultaneous clear.
            err <= (err & ~{4{err_clr}}) | w_fail;
        end
    end

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Directed bench for vga_frame_monitor on a reduced 8x4 raster, with an
// active-low and an active-high sync build driven from the same stream.
module tb_vga_frame_monitor;

    localparam int RGB_W     = 12;
    localparam int H_DISPLAY = 8;
    localparam int H_SYNC    = 3;
    localparam int H_BACK    = 2;
    localparam int H_TOTAL   = 16;
    localparam int V_DISPLAY = 4;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 1;
    localparam int V_TOTAL   = 9;
    localparam int H_ACT     = H_SYNC + H_BACK;
    localparam int V_ACT     = V_SYNC + V_BACK;
    localparam int FRAME_PIX = H_DISPLAY * V_DISPLAY;
    localparam int NO_LIMIT  = 1 << 30;

    logic             clk = 1'b0;
    logic             reset, p_tick, hs_act, vs_act, err_clr;
    logic [RGB_W-1:0] rgb;
    logic             o_locked [2];
    logic             o_fv     [2];
    logic [15:0]      o_crc    [2];
    logic [19:0]      o_pix    [2];
    logic [3:0]       o_err    [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Stream shaping knobs used by run_frame.
    int pattern      = 0;
    int bad_hsw_line = -1;
    int bad_hsw      = H_SYNC;
    int short_line   = -1;
    int clr_line     = -1;
    int cap_line     = -1;
    int cap_h        = -1;

    // Observations at the first tick of a frame (the vsync edge closing the previous one).
    logic        e_fv     [2];
    logic        e_locked [2];
    logic [15:0] e_crc    [2];
    logic [19:0] e_pix    [2];
    logic [3:0]  e_err    [2];
    logic        cap_locked;
    logic [3:0]  cap_err;

    // Model of the frame being generated (m_) and of the frame just closed (p_).
    logic [15:0] m_crc, p_crc, nom_crc;
    int          m_pix, p_pix;

    always #5 clk = ~clk;

    vga_frame_monitor #(
        .RGB_W(RGB_W), .H_DISPLAY(H_DISPLAY), .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_TOTAL(H_TOTAL),
        .V_DISPLAY(V_DISPLAY), .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_TOTAL(V_TOTAL), .SYNC_POL(1'b0)
    ) dut_lo (
        .clk(clk), .reset(reset), .p_tick(p_tick), .hsync(~hs_act), .vsync(~vs_act),
        .rgb(rgb), .err_clr(err_clr), .locked(o_locked[0]), .frame_valid(o_fv[0]),
        .frame_crc(o_crc[0]), .frame_pix(o_pix[0]), .err(o_err[0])
    );

    vga_frame_monitor #(
        .RGB_W(RGB_W), .H_DISPLAY(H_DISPLAY), .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_TOTAL(H_TOTAL),
        .V_DISPLAY(V_DISPLAY), .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_TOTAL(V_TOTAL), .SYNC_POL(1'b1)
    ) dut_hi (
        .clk(clk), .reset(reset), .p_tick(p_tick), .hsync(hs_act), .vsync(vs_act),
        .rgb(rgb), .err_clr(err_clr), .locked(o_locked[1]), .frame_valid(o_fv[1]),
        .frame_crc(o_crc[1]), .frame_pix(o_pix[1]), .err(o_err[1])
    );

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [RGB_W-1:0] d);
        logic [15:0] r;
        r = c;
        for (int i = RGB_W - 1; i >= 0; i--) begin
            if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    // One pixel tick: three idle clocks, then one clock with p_tick high; returns at a negedge.
    task automatic tick(input logic hs, input logic vs, input logic [RGB_W-1:0] px, input logic clr);
        repeat (3) @(negedge clk);
        hs_act  = hs;
        vs_act  = vs;
        rgb     = px;
        err_clr = clr;
        p_tick  = 1'b1;
        @(negedge clk);
        p_tick  = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic run_frame(input int n_lines, input int max_ticks);
        int n;
        n     = 0;
        p_crc = m_crc;
        p_pix = m_pix;
        m_crc = 16'hFFFF;
        m_pix = 0;
        for (int l = 0; l < n_lines; l++) begin
            int len;
            int hsw;
            len = (l == short_line)   ? H_TOTAL - 1 : H_TOTAL;
            hsw = (l == bad_hsw_line) ? bad_hsw     : H_SYNC;
            for (int h = 0; h < len; h++) begin
                logic [RGB_W-1:0] px;
                logic             act;
                px  = (pattern != 0) ? RGB_W'(h ^ l) : '0;
                act = (h >= H_ACT) && (h < H_ACT + H_DISPLAY) && (l >= V_ACT) && (l < V_ACT + V_DISPLAY);
                if (n == max_ticks) return;
                tick(h < hsw, l < V_SYNC, px, (l == clr_line) && (h == 0));
                n++;
                if (n == 1) begin
                    for (int d = 0; d < 2; d++) begin
                        e_fv[d]     = o_fv[d];
                        e_locked[d] = o_locked[d];
                        e_crc[d]    = o_crc[d];
                        e_pix[d]    = o_pix[d];
                        e_err[d]    = o_err[d];
                    end
                end
                if ((l == cap_line) && (h == cap_h)) begin
                    cap_locked = o_locked[0];
                    cap_err    = o_err[0];
                end
                if (act) begin
                    m_crc = crc_step(m_crc, px);
                    m_pix++;
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (4) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if ({o_locked[d], o_fv[d], o_crc[d], o_pix[d], o_err[d]} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs dut%0d: got lk=%b fv=%b crc=%h pix=%0d err=%b, want all 0",
                         d, o_locked[d], o_fv[d], o_crc[d], o_pix[d], o_err[d]);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_clean_frames();
        pattern = 0;
        run_frame(V_TOTAL, NO_LIMIT);
        n_checks++;
        if ({e_fv[0], e_locked[0]} !== 2'b00) begin
            n_fail++;
            $display("FAIL first_edge: got fv=%b lk=%b, want fv=0 lk=0", e_fv[0], e_locked[0]);
        end
        for (int f = 2; f <= 3; f++) begin
            run_frame(V_TOTAL, NO_LIMIT);
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if ({e_fv[d], e_locked[d], e_err[d]} !== 6'b110000) begin
                    n_fail++;
                    $display("FAIL clean_edge%0d dut%0d: got fv=%b lk=%b err=%b, want fv=1 lk=1 err=0000",
                             f, d, e_fv[d], e_locked[d], e_err[d]);
                end
                n_checks++;
                if (e_pix[d] !== 20'(FRAME_PIX) || e_crc[d] !== p_crc) begin
                    n_fail++;
                    $display("FAIL clean_result%0d dut%0d: got pix=%0d crc=%h, want pix=%0d crc=%h",
                             f, d, e_pix[d], e_crc[d], FRAME_PIX, p_crc);
                end
            end
        end
    endtask

    task automatic test_pattern();
        pattern = 1;
        // The first edge here still closes the last all-zero frame.
        for (int f = 0; f < 3; f++) begin
            run_frame(V_TOTAL, NO_LIMIT);
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (e_fv[d] !== 1'b1 || e_crc[d] !== p_crc || e_pix[d] !== 20'(FRAME_PIX)) begin
                    n_fail++;
                    $display("FAIL pattern_crc%0d dut%0d: got fv=%b crc=%h pix=%0d, want fv=1 crc=%h pix=%0d",
                             f, d, e_fv[d], e_crc[d], e_pix[d], p_crc, FRAME_PIX);
                end
            end
        end
        nom_crc = p_crc;
    endtask

    task automatic test_hsync_width();
        bad_hsw_line = 4;
        bad_hsw      = H_SYNC - 1;
        cap_line     = 4;
        cap_h        = H_SYNC - 1;
        run_frame(V_TOTAL, NO_LIMIT);
        n_checks++;
        if (e_locked[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL hwidth_prelock: got lk=%b, want 1", e_locked[0]);
        end
        n_checks++;
        if (cap_err !== 4'b0001 || cap_locked !== 1'b0) begin
            n_fail++;
            $display("FAIL hwidth_flag: got err=%b lk=%b, want err=0001 lk=0", cap_err, cap_locked);
        end
        bad_hsw_line = -1;
        cap_line     = -1;
        run_frame(V_TOTAL, NO_LIMIT);
        n_checks++;
        if (e_fv[0] !== 1'b0 || e_locked[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL hwidth_no_valid: got fv=%b lk=%b, want fv=0 lk=0", e_fv[0], e_locked[0]);
        end
        run_frame(V_TOTAL, NO_LIMIT);
        n_checks++;
        if (e_fv[0] !== 1'b1 || e_locked[0] !== 1'b1 || e_crc[0] !== nom_crc || e_err[0] !== 4'b0001) begin
            n_fail++;
            $display("FAIL hwidth_relock: got fv=%b lk=%b crc=%h err=%b, want fv=1 lk=1 crc=%h err=0001",
                     e_fv[0], e_locked[0], e_crc[0], e_err[0], nom_crc);
        end
    endtask

    task automatic test_short_frame();
        run_frame(V_TOTAL - 1, NO_LIMIT);
        run_frame(V_TOTAL, NO_LIMIT);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (e_err[d] !== 4'b1001 || e_fv[d] !== 1'b0 || e_locked[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL vperiod dut%0d: got err=%b fv=%b lk=%b, want err=1001 fv=0 lk=0",
                         d, e_err[d], e_fv[d], e_locked[d]);
            end
        end
    endtask

    task automatic test_err_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        n_checks++;
        if (o_err[0] !== 4'b0000) begin
            n_fail++;
            $display("FAIL clr_alone_1: got err=%b, want 0000", o_err[0]);
        end
        short_line = 2;
        clr_line   = 3;
        cap_line   = 3;
        cap_h      = 0;
        run_frame(V_TOTAL, NO_LIMIT);
        n_checks++;
        if (e_fv[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_prev_valid: got fv=%b, want 1", e_fv[0]);
        end
        n_checks++;
        if (cap_err !== 4'b0010) begin
            n_fail++;
            $display("FAIL clr_vs_set: got err=%b, want 0010", cap_err);
        end
        short_line = -1;
        clr_line   = -1;
        cap_line   = -1;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        n_checks++;
        if (o_err[0] !== 4'b0000) begin
            n_fail++;
            $display("FAIL clr_alone_2: got err=%b, want 0000", o_err[0]);
        end
        run_frame(V_TOTAL, NO_LIMIT);
        n_checks++;
        if (e_fv[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL hperiod_no_valid: got fv=%b, want 0", e_fv[0]);
        end
    endtask

    task automatic test_mid_reset();
        run_frame(V_TOTAL, NO_LIMIT);
        run_frame(V_TOTAL, 50);
        n_checks++;
        if (o_locked[0] !== 1'b1 || o_locked[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL prereset_lock: got lk=%b/%b, want 1/1", o_locked[0], o_locked[1]);
        end
        reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if ({o_locked[d], o_fv[d], o_crc[d], o_pix[d], o_err[d]} !== '0) begin
                n_fail++;
                $display("FAIL midreset_outputs dut%0d: got lk=%b fv=%b crc=%h pix=%0d err=%b, want all 0",
                         d, o_locked[d], o_fv[d], o_crc[d], o_pix[d], o_err[d]);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        run_frame(V_TOTAL, NO_LIMIT);
        n_checks++;
        if (e_fv[1] !== 1'b0 || e_locked[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL reacq_edge: got fv=%b lk=%b, want fv=0 lk=0", e_fv[1], e_locked[1]);
        end
        run_frame(V_TOTAL, NO_LIMIT);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (e_fv[d] !== 1'b1 || e_locked[d] !== 1'b1 || e_crc[d] !== nom_crc
                || e_pix[d] !== 20'(FRAME_PIX) || e_err[d] !== 4'b0000) begin
                n_fail++;
                $display("FAIL relock dut%0d: got fv=%b lk=%b crc=%h pix=%0d err=%b, want fv=1 lk=1 crc=%h pix=%0d err=0000",
                         d, e_fv[d], e_locked[d], e_crc[d], e_pix[d], e_err[d], nom_crc, FRAME_PIX);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        reset   = 1'b1;
        p_tick  = 1'b0;
        hs_act  = 1'b0;
        vs_act  = 1'b0;
        rgb     = '0;
        err_clr = 1'b0;
        m_crc   = 16'hFFFF;
        m_pix   = 0;
        nom_crc = '0;
        test_reset();
        test_clean_frames();
        test_pattern();
        test_hsync_width();
        test_short_frame();
        test_err_clr();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
